// File: rtl/iq_sample_buffer_pkg.sv
// ---------------------------------------------------------------------------
// iq_sample_buffer_pkg
// Shared encodings for the I/Q capture buffer: write-channel FSM states and
// write-response codes.
// ---------------------------------------------------------------------------
package iq_sample_buffer_pkg;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  localparam logic BRESP_OKAY  = 1'b0;
  localparam logic BRESP_RANGE = 1'b1;

endpackage

// File: rtl/iq_sample_buffer_ram.sv
// ---------------------------------------------------------------------------
// iq_sample_ram
// Simple dual-port sample store: one synchronous write port and one
// synchronous read port. A read and a write to the same slot in the same
// cycle return the old contents. The array has no reset, so it maps onto
// block RAM.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write slot
//   wdata  write data
//   re     read enable; rdata holds when low
//   raddr  read slot
//   rdata  registered read data
// ---------------------------------------------------------------------------
module iq_sample_ram #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-slot read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/iq_sample_buffer.sv
// ---------------------------------------------------------------------------
// iq_sample_buffer
// Capture-buffer responder. It accepts one packed I/Q sample per write
// handshake and returns a write response. It serves addressed reads through
// a single back-pressurable output register, and it counts the distinct
// in-range slots written since reset.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_axi_waddr/wvalid/wdata   write request ({I, Q} packed, I on top)
//   s_axi_wready        write request accepted when wvalid is high
//   s_axi_bresp/bvalid  write response (1 = address out of range)
//   m_axi_bready        response consumed
//   m_axi_raddr/rvalid  read request
//   s_axi_rready        read request accepted when rvalid is high
//   i_out, q_out        read data
//   s_axi_rdata_valid   read data valid
//   m_axi_rready        read data consumed
//   fill_count, full    occupancy
// ---------------------------------------------------------------------------
module iq_sample_buffer
  import iq_sample_buffer_pkg::*;
#(
  parameter int BUFFER_LENGTH = 64,
  parameter int INDEX_BITS    = 6,
  parameter int I_BITS        = 12,
  parameter int Q_BITS        = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_BITS-1:0]    m_axi_waddr,
  input  logic                     m_axi_wvalid,
  input  logic [I_BITS+Q_BITS-1:0] m_axi_wdata,
  output logic                     s_axi_wready,
  output logic                     s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     m_axi_bready,
  input  logic [INDEX_BITS-1:0]    m_axi_raddr,
  input  logic                     m_axi_rvalid,
  output logic                     s_axi_rready,
  output logic [I_BITS-1:0]        i_out,
  output logic [Q_BITS-1:0]        q_out,
  output logic                     s_axi_rdata_valid,
  input  logic                     m_axi_rready,
  output logic [INDEX_BITS:0]      fill_count,
  output logic                     full
);

  localparam int DATA_BITS = I_BITS + Q_BITS;
  localparam int RAM_BITS  = (BUFFER_LENGTH > 1) ? $clog2(BUFFER_LENGTH) : 1;
  localparam logic [INDEX_BITS:0] LEN = (INDEX_BITS+1)'(BUFFER_LENGTH);
  localparam logic [INDEX_BITS:0] ONE = (INDEX_BITS+1)'(1);

  wstate_t state, state_nxt;

  logic                     w_accept, w_in_range, w_store;
  logic                     r_accept, r_in_range;
  logic                     r_zero;
  logic [RAM_BITS-1:0]      w_idx, r_idx;
  logic [BUFFER_LENGTH-1:0] written;
  logic [DATA_BITS-1:0]     ram_rdata;

  // In-range addresses always fit in RAM_BITS, so the truncated index is
  // only ever used on in-range accesses (out-of-range reads are masked).
  assign w_idx      = m_axi_waddr[RAM_BITS-1:0];
  assign r_idx      = m_axi_raddr[RAM_BITS-1:0];
  assign w_in_range = {1'b0, m_axi_waddr} < LEN;
  assign r_in_range = {1'b0, m_axi_raddr} < LEN;
  assign w_accept   = m_axi_wvalid && s_axi_wready;
  assign w_store    = w_accept && w_in_range;

  // Write FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= W_IDLE;
    else     state <= state_nxt;
  end

  // Write FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (m_axi_wvalid) state_nxt = W_RESP;
      W_RESP:  if (m_axi_bready) state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    s_axi_wready = 1'b0;
    s_axi_bvalid = 1'b0;
    case (state)
      W_IDLE:  s_axi_wready = 1'b1;
      W_RESP:  s_axi_bvalid = 1'b1;
      default: s_axi_wready = 1'b0;
    endcase
  end

  // The response code is captured at accept and held through W_RESP.
  always_ff @(posedge clk) begin
    if (rst)           s_axi_bresp <= BRESP_OKAY;
    else if (w_accept) s_axi_bresp <= w_in_range ? BRESP_OKAY : BRESP_RANGE;
  end

  // Occupancy: count a slot only on its first store since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      written    <= '0;
      fill_count <= '0;
    end else if (w_store) begin
      written[w_idx] <= 1'b1;
      if (!written[w_idx] && fill_count != LEN) fill_count <= fill_count + ONE;
    end
  end

  assign full = (fill_count == LEN);

  // Read path. The RAM output register is the data register; r_zero masks it
  // for out-of-range reads and after reset, so the RAM itself needs no reset.
  assign s_axi_rready = !s_axi_rdata_valid || m_axi_rready;
  assign r_accept     = m_axi_rvalid && s_axi_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rdata_valid <= 1'b0;
      r_zero            <= 1'b1;
    end else if (r_accept) begin
      s_axi_rdata_valid <= 1'b1;
      r_zero            <= !r_in_range;
    end else if (m_axi_rready) begin
      s_axi_rdata_valid <= 1'b0;
    end
  end

  assign i_out = r_zero ? '0 : ram_rdata[DATA_BITS-1 -: I_BITS];
  assign q_out = r_zero ? '0 : ram_rdata[Q_BITS-1:0];

  iq_sample_ram #(
    .DEPTH    (BUFFER_LENGTH),
    .ADDR_BITS(RAM_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (w_store),
    .waddr(w_idx),
    .wdata(m_axi_wdata),
    .re   (r_accept),
    .raddr(r_idx),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_iq_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_iq_sample_buffer
// Directed bench for iq_sample_buffer (64 slots, 7-bit addresses so that
// out-of-range addresses can be driven). A transaction-level reference
// model tracks the expected handshake outputs, memory and occupancy. A
// compare process checks it against the DUT every cycle, and directed
// steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_iq_sample_buffer;

  localparam int LEN = 64;
  localparam int IB  = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IB-1:0] m_axi_waddr = '0;
  logic          m_axi_wvalid = 1'b0;
  logic [23:0]   m_axi_wdata = '0;
  logic          s_axi_wready, s_axi_bresp, s_axi_bvalid;
  logic          m_axi_bready = 1'b0;
  logic [IB-1:0] m_axi_raddr = '0;
  logic          m_axi_rvalid = 1'b0;
  logic          s_axi_rready;
  logic [11:0]   i_out, q_out;
  logic          s_axi_rdata_valid;
  logic          m_axi_rready = 1'b0;
  logic [IB:0]   fill_count;
  logic          full;

  always #5 clk = ~clk;

  iq_sample_buffer #(
    .BUFFER_LENGTH(LEN), .INDEX_BITS(IB), .I_BITS(12), .Q_BITS(12)
  ) dut (
    .clk(clk), .rst(rst),
    .m_axi_waddr(m_axi_waddr), .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_raddr(m_axi_raddr), .m_axi_rvalid(m_axi_rvalid), .s_axi_rready(s_axi_rready),
    .i_out(i_out), .q_out(q_out), .s_axi_rdata_valid(s_axi_rdata_valid),
    .m_axi_rready(m_axi_rready),
    .fill_count(fill_count), .full(full)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] m_mem     [128];
  bit          m_known   [128];
  bit          m_written [128];
  bit          e_wready = 1'b1, e_bvalid = 1'b0, e_bresp = 1'b0;
  bit          e_rvalid = 1'b0, e_dknown = 1'b0;
  logic [23:0] e_data = '0;
  int          e_fill = 0;

  initial begin
    for (int k = 0; k < 128; k++) begin
      m_known[k]   = 1'b0;
      m_written[k] = 1'b0;
      m_mem[k]     = '0;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        e_wready = 1'b1; e_bvalid = 1'b0; e_bresp = 1'b0;
        e_rvalid = 1'b0; e_fill = 0;
        for (int k = 0; k < 128; k++) m_written[k] = 1'b0;
      end else begin
        // read is evaluated before the write so same-slot accesses see old data
        if (m_axi_rvalid && (!e_rvalid || m_axi_rready)) begin
          e_rvalid = 1'b1;
          if (int'(m_axi_raddr) < LEN) begin
            e_data   = m_mem[m_axi_raddr];
            e_dknown = m_known[m_axi_raddr];
          end else begin
            e_data   = '0;
            e_dknown = 1'b1;
          end
        end else if (m_axi_rready) begin
          e_rvalid = 1'b0;
        end
        if (e_wready && m_axi_wvalid) begin
          if (int'(m_axi_waddr) < LEN) begin
            m_mem[m_axi_waddr]   = m_axi_wdata;
            m_known[m_axi_waddr] = 1'b1;
            if (!m_written[m_axi_waddr]) begin
              m_written[m_axi_waddr] = 1'b1;
              e_fill++;
            end
            e_bresp = 1'b0;
          end else begin
            e_bresp = 1'b1;
          end
          e_wready = 1'b0;
          e_bvalid = 1'b1;
        end else if (e_bvalid && m_axi_bready) begin
          e_bvalid = 1'b0;
          e_wready = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_wready", 32'(s_axi_wready), 32'(e_wready));
        chk("m_bvalid", 32'(s_axi_bvalid), 32'(e_bvalid));
        chk("m_bresp",  32'(s_axi_bresp),  32'(e_bresp));
        chk("m_rdvalid", 32'(s_axi_rdata_valid), 32'(e_rvalid));
        chk("m_rready", 32'(s_axi_rready), 32'(!e_rvalid || m_axi_rready));
        chk("m_fill",   32'(fill_count),   32'(e_fill));
        chk("m_full",   32'(full),         32'(e_fill == LEN));
        if (e_rvalid && e_dknown) chk("m_rdata", 32'({i_out, q_out}), 32'(e_data));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [23:0] exp_data [LEN];
  logic [23:0] pat;
  logic [23:0] got [$];

  function automatic logic [23:0] patf(input int a);
    logic [11:0] iv, qv;
    iv = 12'(a * 7 + 1);
    qv = 12'(a) ^ 12'h5A5;
    return {iv, qv};
  endfunction

  task automatic wr(input int a, input logic [23:0] d);
    int n;
    @(negedge clk); #1;
    m_axi_waddr = IB'(a); m_axi_wdata = d; m_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_wready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("wr_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    m_axi_wvalid = 1'b0;
  endtask

  task automatic rd(input int a);
    int n;
    @(negedge clk); #1;
    m_axi_raddr = IB'(a); m_axi_rvalid = 1'b1;
    n = 0;
    while (!s_axi_rready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("rd_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    m_axi_rvalid = 1'b0;
  endtask

  initial begin
    int n, ra;
    bit acc;
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, ra;
    bit acc;
    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_wready", 32'(s_axi_wready), 1);
    chk("rst_bvalid", 32'(s_axi_bvalid), 0);
    chk("rst_bresp",  32'(s_axi_bresp), 0);
    chk("rst_rdvalid", 32'(s_axi_rdata_valid), 0);
    chk("rst_iq", 32'({i_out, q_out}), 0);
    chk("rst_fill", 32'(fill_count), 0);
    chk("rst_full", 32'(full), 0);
    #1 rst = 1'b0; m_axi_bready = 1'b1; m_axi_rready = 1'b1;

    // basic write and read-back
    wr(3, {12'h123, 12'hABC});
    chk("w3_wready", 32'(s_axi_wready), 0);
    chk("w3_bvalid", 32'(s_axi_bvalid), 1);
    chk("w3_bresp",  32'(s_axi_bresp), 0);
    chk("w3_fill",   32'(fill_count), 1);
    @(negedge clk);
    chk("w3_wready_back", 32'(s_axi_wready), 1);
    rd(3);
    chk("r3_valid", 32'(s_axi_rdata_valid), 1);
    chk("r3_i", 32'(i_out), 'h123);
    chk("r3_q", 32'(q_out), 'hABC);

    // out-of-range write and read
    wr(70, 24'h777888);
    chk("w70_bresp", 32'(s_axi_bresp), 1);
    chk("w70_fill",  32'(fill_count), 1);
    rd(70);
    chk("r70_valid", 32'(s_axi_rdata_valid), 1);
    chk("r70_i", 32'(i_out), 0);
    chk("r70_q", 32'(q_out), 0);

    // response back-pressure; a second request waits for the handshake
    @(negedge clk); #1;
    m_axi_bready = 1'b0;
    m_axi_waddr = 7'd5; m_axi_wdata = 24'h55AA55; m_axi_wvalid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(s_axi_bvalid), 1);
      chk("bp_bresp",  32'(s_axi_bresp), 0);
      chk("bp_wready", 32'(s_axi_wready), 0);
      chk("bp_fill",   32'(fill_count), 2);
      if (k == 0) begin m_axi_waddr = 7'd6; m_axi_wdata = 24'h666999; end
    end
    #1 m_axi_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_wready", 32'(s_axi_wready), 1);
    chk("bp_release_bvalid", 32'(s_axi_bvalid), 0);
    chk("bp_release_fill",   32'(fill_count), 2);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_bvalid", 32'(s_axi_bvalid), 1);
    chk("bp_second_fill",   32'(fill_count), 3);
    m_axi_wvalid = 1'b0;

    // fill every slot, then rewrite slot 0
    for (int a = 0; a < LEN; a++) begin
      pat = patf(a);
      exp_data[a] = pat;
      wr(a, pat);
      if (a == 62) begin
        chk("fill63", 32'(fill_count), 63);
        chk("full63", 32'(full), 0);
      end
    end
    chk("fill64", 32'(fill_count), 64);
    chk("full64", 32'(full), 1);
    wr(0, 24'hABCDEF);
    exp_data[0] = 24'hABCDEF;
    chk("rewrite_fill", 32'(fill_count), 64);
    chk("rewrite_full", 32'(full), 1);

    // streamed reads with toggling rready
    got.delete();
    n = 0; ra = 0;
    @(negedge clk); #1;
    m_axi_raddr = '0; m_axi_rvalid = 1'b1;
    while (got.size() < LEN && n < 400) begin
      m_axi_rready = (n % 2 == 0);
      #1;
      if (s_axi_rdata_valid && m_axi_rready) got.push_back({i_out, q_out});
      acc = m_axi_rvalid && s_axi_rready;
      @(negedge clk); #1;
      n++;
      if (acc) begin
        ra++;
        if (ra < LEN) m_axi_raddr = IB'(ra);
        else m_axi_rvalid = 1'b0;
      end
    end
    chk("stream_count", 32'(got.size()), LEN);
    for (int k = 0; k < LEN && k < got.size(); k++)
      chk($sformatf("stream_%0d", k), 32'(got[k]), 32'(exp_data[k]));
    m_axi_rvalid = 1'b0; m_axi_rready = 1'b1;
    repeat (3) @(negedge clk);

    // reset during a pending response and pending read data
    #1;
    m_axi_bready = 1'b0; m_axi_rready = 1'b0;
    m_axi_waddr = 7'd10; m_axi_wdata = 24'h10A10B; m_axi_wvalid = 1'b1;
    m_axi_raddr = 7'd3; m_axi_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_axi_wvalid = 1'b0; m_axi_rvalid = 1'b0;
    pat = exp_data[3];
    chk("pend_bvalid", 32'(s_axi_bvalid), 1);
    chk("pend_rdvalid", 32'(s_axi_rdata_valid), 1);
    chk("pend_data", 32'({i_out, q_out}), 32'(pat));
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_bvalid", 32'(s_axi_bvalid), 0);
    chk("mrst_rdvalid", 32'(s_axi_rdata_valid), 0);
    chk("mrst_wready", 32'(s_axi_wready), 1);
    chk("mrst_fill", 32'(fill_count), 0);
    chk("mrst_full", 32'(full), 0);
    chk("mrst_iq", 32'({i_out, q_out}), 0);
    #1 rst = 1'b0; m_axi_bready = 1'b1; m_axi_rready = 1'b1;
    rd(3);
    chk("post_r3", 32'({i_out, q_out}), 32'(pat));
    rd(10);
    chk("post_r10_i", 32'(i_out), 'h10A);
    chk("post_r10_q", 32'(q_out), 'h10B);
    wr(3, pat);
    chk("post_fill", 32'(fill_count), 1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
